pipeline_hazard_ctrl: RTL

//  Hazard and sequencing controller for the 5-stage pipeline (IF/ID/EX/MEM/WB).

---
 rtl/pipeline_hazard_ctrl_if.sv | 50 +++++
 rtl/pipeline_hazard_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: ID source fields, EX/MEM/WB destinations, and the
// pipeline control/forwarding outputs. Directions are named from the controller's side.
interface pipeline_hazard_ctrl_if #(
    parameter int RA_W  = 4,
    parameter int CNT_W = 16
);
    logic [RA_W-1:0]  id_rn_i;
    logic [RA_W-1:0]  id_rm_i;
    logic [RA_W-1:0]  id_rd_i;
    logic             id_use_rn_i;
    logic             id_use_rm_i;
    logic             id_use_rd_i;
    logic [RA_W-1:0]  ex_rd_i;
    logic [RA_W-1:0]  mem_rd_i;
    logic [RA_W-1:0]  wb_rd_i;
    logic             ex_rf_en_i;
    logic             mem_rf_en_i;
    logic             wb_rf_en_i;
    logic             ex_load_i;
    logic             branch_taken_i;
    logic             mem_busy_i;

    logic             pc_ld_o;
    logic             ifid_ld_o;
    logic             ifid_clr_o;
    logic             idex_nop_o;
    logic             pipe_hold_o;
    logic [1:0]       fwd_a_o;
    logic [1:0]       fwd_b_o;
    logic [1:0]       fwd_c_o;
    logic             mem_timeout_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport slave (
        input  id_rn_i, id_rm_i, id_rd_i, id_use_rn_i, id_use_rm_i, id_use_rd_i,
        input  ex_rd_i, mem_rd_i, wb_rd_i, ex_rf_en_i, mem_rf_en_i, wb_rf_en_i,
        input  ex_load_i, branch_taken_i, mem_busy_i,
        output pc_ld_o, ifid_ld_o, ifid_clr_o, idex_nop_o, pipe_hold_o,
        output fwd_a_o, fwd_b_o, fwd_c_o, mem_timeout_o, stall_cnt_o, flush_cnt_o
    );

    modport master (
        output id_rn_i, id_rm_i, id_rd_i, id_use_rn_i, id_use_rm_i, id_use_rd_i,
        output ex_rd_i, mem_rd_i, wb_rd_i, ex_rf_en_i, mem_rf_en_i, wb_rf_en_i,
        output ex_load_i, branch_taken_i, mem_busy_i,
        input  pc_ld_o, ifid_ld_o, ifid_clr_o, idex_nop_o, pipe_hold_o,
        input  fwd_a_o, fwd_b_o, fwd_c_o, mem_timeout_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for a 5-stage pipeline: RAW stalls, branch flush,
// data-RAM wait freeze, operand forwarding. Optional feature macro: PPU_FORWARDING_EN.
module pipeline_hazard_ctrl #(
    parameter int RA_W     = 4,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    pipeline_hazard_ctrl_if.slave   bus
);

    localparam int WAIT_W = $clog2(WAIT_MAX + 1);
    localparam logic [RA_W-1:0]   PC_REG   = RA_W'(15);
    localparam logic [WAIT_W-1:0] WAIT_TOP = WAIT_W'(WAIT_MAX);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

    // R15 reads the PC, so it never participates in a hazard.
    function automatic logic reg_match(
        input logic            use_x,
        input logic [RA_W-1:0] x,
        input logic            rf_en,
        input logic [RA_W-1:0] rd
    );
        return use_x && rf_en && (x == rd) && (x != PC_REG);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [WAIT_W-1:0] wait_inc(input logic [WAIT_W-1:0] v);
        return (v >= WAIT_TOP) ? WAIT_TOP : v + WAIT_W'(1);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic m_ex, input logic m_mem, input logic m_wb);
        logic [1:0] sel;
        if (m_ex) begin
            sel = 2'b01;
        end else if (m_mem) begin
            sel = 2'b10;
        end else if (m_wb) begin
            sel = 2'b11;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic [2:0] m_ex_s, m_mem_s, m_wb_s;
    logic       raw_stall_s;
    logic [1:0] fwd_a_s, fwd_b_s, fwd_c_s;
    logic       pc_ld_s, ifid_ld_s, ifid_clr_s, idex_nop_s, pipe_hold_s;

    // Source-vs-destination comparisons: bit 0 rn, bit 1 rm, bit 2 rd.
    always_comb begin
        m_ex_s[0]  = reg_match(bus.id_use_rn_i, bus.id_rn_i, bus.ex_rf_en_i,  bus.ex_rd_i);
        m_ex_s[1]  = reg_match(bus.id_use_rm_i, bus.id_rm_i, bus.ex_rf_en_i,  bus.ex_rd_i);
        m_ex_s[2]  = reg_match(bus.id_use_rd_i, bus.id_rd_i, bus.ex_rf_en_i,  bus.ex_rd_i);
        m_mem_s[0] = reg_match(bus.id_use_rn_i, bus.id_rn_i, bus.mem_rf_en_i, bus.mem_rd_i);
        m_mem_s[1] = reg_match(bus.id_use_rm_i, bus.id_rm_i, bus.mem_rf_en_i, bus.mem_rd_i);
        m_mem_s[2] = reg_match(bus.id_use_rd_i, bus.id_rd_i, bus.mem_rf_en_i, bus.mem_rd_i);
        m_wb_s[0]  = reg_match(bus.id_use_rn_i, bus.id_rn_i, bus.wb_rf_en_i,  bus.wb_rd_i);
        m_wb_s[1]  = reg_match(bus.id_use_rm_i, bus.id_rm_i, bus.wb_rf_en_i,  bus.wb_rd_i);
        m_wb_s[2]  = reg_match(bus.id_use_rd_i, bus.id_rd_i, bus.wb_rf_en_i,  bus.wb_rd_i);
    end

`ifdef PPU_FORWARDING_EN
    // Bypass covers everything except a load result that is still in EX.
    always_comb begin
        raw_stall_s = bus.ex_load_i && (|m_ex_s);
        fwd_a_s     = fwd_sel(m_ex_s[0], m_mem_s[0], m_wb_s[0]);
        fwd_b_s     = fwd_sel(m_ex_s[1], m_mem_s[1], m_wb_s[1]);
        fwd_c_s     = fwd_sel(m_ex_s[2], m_mem_s[2], m_wb_s[2]);
    end
`else
    logic unused_ex_load_s;
    assign unused_ex_load_s = bus.ex_load_i;

    // Without bypass, ID waits until the producer has left WB.
    always_comb begin
        raw_stall_s = (|m_ex_s) || (|m_mem_s) || (|m_wb_s);
        fwd_a_s     = 2'b00;
        fwd_b_s     = 2'b00;
        fwd_c_s     = 2'b00;
    end
`endif

    // Next state, counters and datapath controls; priority reset > busy > stall > flush.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        pc_ld_s       = 1'b1;
        ifid_ld_s     = 1'b1;
        ifid_clr_s    = 1'b0;
        idex_nop_s    = 1'b0;
        pipe_hold_s   = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (bus.mem_busy_i) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = wait_inc(WAIT_W'(0));
                end else begin
                    wait_cnt_d = WAIT_W'(0);
                end
            end
            ST_MEM_WAIT: begin
                if (bus.mem_busy_i) begin
                    wait_cnt_d = wait_inc(wait_cnt_q);
                end else begin
                    state_d    = ST_RUN;
                    wait_cnt_d = WAIT_W'(0);
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = WAIT_W'(0);
            end
        endcase

        if (wait_cnt_d == WAIT_TOP) begin
            mem_timeout_d = 1'b1;
        end else begin
            mem_timeout_d = mem_timeout_q;
        end

        if (reset) begin
            pc_ld_s    = 1'b0;
            ifid_ld_s  = 1'b0;
            ifid_clr_s = 1'b1;
            idex_nop_s = 1'b1;
        end else if (bus.mem_busy_i) begin
            pc_ld_s     = 1'b0;
            ifid_ld_s   = 1'b0;
            pipe_hold_s = 1'b1;
        end else if (raw_stall_s) begin
            pc_ld_s     = 1'b0;
            ifid_ld_s   = 1'b0;
            idex_nop_s  = 1'b1;
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else if (bus.branch_taken_i) begin
            ifid_clr_s  = 1'b1;
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else begin
            pc_ld_s   = 1'b1;
            ifid_ld_s = 1'b1;
        end
    end

    // State and event registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= WAIT_W'(0);
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= CNT_W'(0);
            flush_cnt_q   <= CNT_W'(0);
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign bus.pc_ld_o       = pc_ld_s;
    assign bus.ifid_ld_o     = ifid_ld_s;
    assign bus.ifid_clr_o    = ifid_clr_s;
    assign bus.idex_nop_o    = idex_nop_s;
    assign bus.pipe_hold_o   = pipe_hold_s;
    assign bus.fwd_a_o       = reset ? 2'b00 : fwd_a_s;
    assign bus.fwd_b_o       = reset ? 2'b00 : fwd_b_s;
    assign bus.fwd_c_o       = reset ? 2'b00 : fwd_c_s;
    assign bus.mem_timeout_o = mem_timeout_q;
    assign bus.stall_cnt_o   = stall_cnt_q;
    assign bus.flush_cnt_o   = flush_cnt_q;

endmodule
